// File: rtl/intr_controller.sv
// Fixed-priority nested interrupt controller with an in-service stack.
// req/vector are combinational from registered state; an irq edge shows up one clock after it is sampled.
module intr_controller #(
  parameter int N_IRQ      = 8,
  parameter int NEST_DEPTH = 4,
  parameter int EDGE_MODE  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_IRQ-1:0]                irq,
  input  logic                            mask_we,
  input  logic [N_IRQ-1:0]                mask_in,
  input  logic                            ack,
  input  logic                            ret,
  output logic                            req,
  output logic [$clog2(N_IRQ)-1:0]        vector,
  output logic [N_IRQ-1:0]                pending,
  output logic [N_IRQ-1:0]                in_service,
  output logic [$clog2(NEST_DEPTH+1)-1:0] depth,
  output logic                            err
);

  localparam int VW = $clog2(N_IRQ);
  localparam int DW = $clog2(NEST_DEPTH+1);
  localparam int SD = 1 << DW;

  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] edge_set;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] pending_n;
  logic [N_IRQ-1:0] in_service_n;
  logic [VW-1:0]    stack [SD];
  logic [VW-1:0]    top;
  logic [DW-1:0]    depth_n;
  logic             armed;
  logic             do_ack;
  logic             do_ret;
  logic             bad;

  // Entry below depth is the most recently accepted channel; ignored when depth is 0.
  assign top = stack[depth - 1'b1];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      eligible[i] = pending[i] & mask[i] & ~in_service[i] &
                    ((depth == '0) | (VW'(i) < top));
    end
    if (depth >= DW'(NEST_DEPTH)) begin
      eligible = '0;
    end
  end

  always_comb begin
    vector = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        vector = VW'(i);
      end
    end
  end

  assign req = |eligible;

  // A simultaneous ret wins over ack; both are flagged as a protocol error.
  assign do_ret = ret & (depth != '0);
  assign do_ack = ack & req & ~ret;
  assign bad    = (ack & ~req) | (ret & (depth == '0)) | (ack & ret);

  always_comb begin
    // The first edge after reset only primes irq_q, so lines already high are not seen as edges.
    edge_set = armed ? (irq & ~irq_q) : '0;
    ack_clr  = do_ack ? (N_IRQ'(1) << vector) : '0;
    if (EDGE_MODE != 0) begin
      pending_n = (pending & ~ack_clr) | edge_set;
    end else begin
      pending_n = irq;
    end

    in_service_n = in_service;
    depth_n      = depth;
    if (do_ret) begin
      in_service_n[top] = 1'b0;
      depth_n           = depth - 1'b1;
    end else if (do_ack) begin
      in_service_n[vector] = 1'b1;
      depth_n              = depth + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q      <= '0;
      armed      <= 1'b0;
      pending    <= '0;
      mask       <= '0;
      in_service <= '0;
      depth      <= '0;
      err        <= 1'b0;
      for (int j = 0; j < SD; j++) begin
        stack[j] <= '0;
      end
    end else begin
      irq_q      <= irq;
      armed      <= 1'b1;
      pending    <= pending_n;
      in_service <= in_service_n;
      depth      <= depth_n;
      if (mask_we) begin
        mask <= mask_in;
      end
      if (do_ack) begin
        stack[depth] <= vector;
      end
      if (bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_intr_controller.sv
// Drives three controller configurations (default, shallow nest, level mode) from shared stimulus
// and compares them to a stack-based reference model.
module tb_intr_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       ack;
  logic       ret;

  logic       o_req  [3];
  logic [2:0] o_vec  [3];
  logic [7:0] o_pend [3];
  logic [7:0] o_isv  [3];
  logic [2:0] o_dep  [3];
  logic       o_err  [3];
  logic [2:0] dep0;
  logic [1:0] dep1;
  logic [2:0] dep2;

  assign o_dep[0] = dep0;
  assign o_dep[1] = {1'b0, dep1};
  assign o_dep[2] = dep2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  intr_controller dut (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .ack(ack), .ret(ret), .req(o_req[0]), .vector(o_vec[0]), .pending(o_pend[0]),
    .in_service(o_isv[0]), .depth(dep0), .err(o_err[0]));

  intr_controller #(.NEST_DEPTH(2)) dut_shallow (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .ack(ack), .ret(ret), .req(o_req[1]), .vector(o_vec[1]), .pending(o_pend[1]),
    .in_service(o_isv[1]), .depth(dep1), .err(o_err[1]));

  intr_controller #(.EDGE_MODE(0)) dut_level (
    .clk(clk), .reset(reset), .irq(irq), .mask_we(mask_we), .mask_in(mask_in),
    .ack(ack), .ret(ret), .req(o_req[2]), .vector(o_vec[2]), .pending(o_pend[2]),
    .in_service(o_isv[2]), .depth(dep2), .err(o_err[2]));

  // Reference model: the nest is a list of accepted channels, in-service is membership in it.
  int       nd [3] = '{4, 2, 4};
  bit       em [3] = '{1'b1, 1'b1, 1'b0};
  bit [7:0] m_pend [3];
  bit [7:0] m_mask [3];
  bit [7:0] m_prev [3];
  bit       m_arm  [3];
  int       m_stk  [3][8];
  int       m_dep  [3];
  bit       m_err  [3];

  function automatic void m_reset();
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = '0; m_mask[k] = '0; m_prev[k] = '0; m_arm[k] = 1'b0;
      m_dep[k] = 0; m_err[k] = 1'b0;
    end
  endfunction

  function automatic bit [7:0] m_isv(input int k);
    bit [7:0] s = '0;
    for (int j = 0; j < m_dep[k]; j++) s[m_stk[k][j]] = 1'b1;
    return s;
  endfunction

  function automatic void m_present(input int k, output bit r, output int v);
    bit [7:0] s;
    int d;
    s = m_isv(k);
    d = m_dep[k];
    r = 1'b0;
    v = 0;
    if (d >= nd[k]) return;
    for (int i = 0; i < 8; i++) begin
      if (!r && m_pend[k][i] && m_mask[k][i] && !s[i] && (d == 0 || i < m_stk[k][d-1])) begin
        r = 1'b1;
        v = i;
      end
    end
  endfunction

  function automatic void m_step();
    for (int k = 0; k < 3; k++) begin
      bit r;
      int v;
      bit [7:0] clr;
      bit [7:0] rise;
      m_present(k, r, v);
      clr = '0;
      if (ack && ret) m_err[k] = 1'b1;
      if (ret) begin
        if (m_dep[k] > 0) m_dep[k]--;
        else m_err[k] = 1'b1;
      end else if (ack) begin
        if (r) begin
          m_stk[k][m_dep[k]] = v;
          m_dep[k]++;
          clr[v] = 1'b1;
        end else begin
          m_err[k] = 1'b1;
        end
      end
      rise = m_arm[k] ? (irq & ~m_prev[k]) : 8'h00;
      if (em[k]) m_pend[k] = (m_pend[k] & ~clr) | rise;
      else m_pend[k] = irq;
      m_prev[k] = irq;
      m_arm[k] = 1'b1;
      if (mask_we) m_mask[k] = mask_in;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (!reset) m_reset();
    else m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; irq = '0; ack = 1'b0; ret = 1'b0; mask_we = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_in = m;
    cyc();
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] p);
    irq = p;
    cyc();
    irq = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1; cyc(); ack = 1'b0;
  endtask

  task automatic do_ret();
    ret = 1'b1; cyc(); ret = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (o_req[0] !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %0h expected 0", o_req[0]); end
    n_cmp++; if (o_vec[0] !== 3'd0) begin n_bad++; $display("FAIL reset_vector: got %0h expected 0", o_vec[0]); end
    n_cmp++; if (o_pend[0] !== 8'h00) begin n_bad++; $display("FAIL reset_pending: got %0h expected 0", o_pend[0]); end
    n_cmp++; if (o_isv[0] !== 8'h00) begin n_bad++; $display("FAIL reset_in_service: got %0h expected 0", o_isv[0]); end
    n_cmp++; if (o_dep[0] !== 3'd0) begin n_bad++; $display("FAIL reset_depth: got %0h expected 0", o_dep[0]); end
    n_cmp++; if (o_err[0] !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0h expected 0", o_err[0]); end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    write_mask(8'hFF);
    pulse(8'h20);
    n_cmp++; if (o_req[0] !== 1'b1) begin n_bad++; $display("FAIL basic_req: got %0h expected 1", o_req[0]); end
    n_cmp++; if (o_vec[0] !== 3'd5) begin n_bad++; $display("FAIL basic_vector: got %0h expected 5", o_vec[0]); end
    n_cmp++; if (o_pend[0] !== 8'h20) begin n_bad++; $display("FAIL basic_pending: got %0h expected 20", o_pend[0]); end
    do_ack();
    n_cmp++; if (o_isv[0] !== 8'h20) begin n_bad++; $display("FAIL basic_ack_isv: got %0h expected 20", o_isv[0]); end
    n_cmp++; if (o_dep[0] !== 3'd1) begin n_bad++; $display("FAIL basic_ack_depth: got %0h expected 1", o_dep[0]); end
    n_cmp++; if (o_pend[0] !== 8'h00) begin n_bad++; $display("FAIL basic_ack_pending: got %0h expected 0", o_pend[0]); end
    n_cmp++; if (o_req[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ack_req: got %0h expected 0", o_req[0]); end
  endtask

  task automatic test_nesting();
    pulse(8'h44);
    n_cmp++; if (o_req[0] !== 1'b1) begin n_bad++; $display("FAIL nest_req: got %0h expected 1", o_req[0]); end
    n_cmp++; if (o_vec[0] !== 3'd2) begin n_bad++; $display("FAIL nest_vector: got %0h expected 2", o_vec[0]); end
    do_ack();
    n_cmp++; if (o_dep[0] !== 3'd2) begin n_bad++; $display("FAIL nest_depth: got %0h expected 2", o_dep[0]); end
    n_cmp++; if (o_isv[0] !== 8'h24) begin n_bad++; $display("FAIL nest_isv: got %0h expected 24", o_isv[0]); end
    n_cmp++; if (o_req[0] !== 1'b0) begin n_bad++; $display("FAIL nest_held_req: got %0h expected 0", o_req[0]); end
    n_cmp++; if (o_pend[0] !== 8'h40) begin n_bad++; $display("FAIL nest_pending: got %0h expected 40", o_pend[0]); end
    ret = 1'b1;
    cyc();
    n_cmp++; if (o_req[0] !== 1'b0) begin n_bad++; $display("FAIL nest_ret1_req: got %0h expected 0", o_req[0]); end
    n_cmp++; if (o_dep[0] !== 3'd1) begin n_bad++; $display("FAIL nest_ret1_depth: got %0h expected 1", o_dep[0]); end
    cyc();
    ret = 1'b0;
    n_cmp++; if (o_req[0] !== 1'b1) begin n_bad++; $display("FAIL nest_ret2_req: got %0h expected 1", o_req[0]); end
    n_cmp++; if (o_vec[0] !== 3'd6) begin n_bad++; $display("FAIL nest_ret2_vector: got %0h expected 6", o_vec[0]); end
    n_cmp++; if (o_isv[0] !== 8'h00) begin n_bad++; $display("FAIL nest_ret2_isv: got %0h expected 0", o_isv[0]); end
    do_ack();
    do_ret();
    n_cmp++; if (o_dep[0] !== 3'd0) begin n_bad++; $display("FAIL nest_end_depth: got %0h expected 0", o_dep[0]); end
    n_cmp++; if (o_err[0] !== 1'b0) begin n_bad++; $display("FAIL nest_end_err: got %0h expected 0", o_err[0]); end
  endtask

  task automatic test_depth_limit();
    do_reset();
    write_mask(8'hFF);
    pulse(8'h08); do_ack();
    pulse(8'h02); do_ack();
    n_cmp++; if (o_dep[1] !== 3'd2) begin n_bad++; $display("FAIL limit_depth: got %0h expected 2", o_dep[1]); end
    pulse(8'h01);
    n_cmp++; if (o_req[1] !== 1'b0) begin n_bad++; $display("FAIL limit_req_full: got %0h expected 0", o_req[1]); end
    n_cmp++; if (o_pend[1] !== 8'h01) begin n_bad++; $display("FAIL limit_pending: got %0h expected 1", o_pend[1]); end
    cyc();
    n_cmp++; if (o_req[1] !== 1'b0) begin n_bad++; $display("FAIL limit_req_hold: got %0h expected 0", o_req[1]); end
    do_ret();
    n_cmp++; if (o_req[1] !== 1'b1) begin n_bad++; $display("FAIL limit_ret_req: got %0h expected 1", o_req[1]); end
    n_cmp++; if (o_vec[1] !== 3'd0) begin n_bad++; $display("FAIL limit_ret_vector: got %0h expected 0", o_vec[1]); end
    n_cmp++; if (o_dep[1] !== 3'd1) begin n_bad++; $display("FAIL limit_ret_depth: got %0h expected 1", o_dep[1]); end
  endtask

  task automatic test_errors();
    do_reset();
    do_ret();
    n_cmp++; if (o_err[0] !== 1'b1) begin n_bad++; $display("FAIL err_ret_empty: got %0h expected 1", o_err[0]); end
    n_cmp++; if (o_dep[0] !== 3'd0) begin n_bad++; $display("FAIL err_ret_depth: got %0h expected 0", o_dep[0]); end
    do_ack();
    n_cmp++; if (o_isv[0] !== 8'h00) begin n_bad++; $display("FAIL err_ack_isv: got %0h expected 0", o_isv[0]); end
    n_cmp++; if (o_dep[0] !== 3'd0) begin n_bad++; $display("FAIL err_ack_depth: got %0h expected 0", o_dep[0]); end
    write_mask(8'hFF);
    pulse(8'h10); do_ack();
    n_cmp++; if (o_isv[0] !== 8'h10) begin n_bad++; $display("FAIL err_setup_isv: got %0h expected 10", o_isv[0]); end
    pulse(8'h02);
    n_cmp++; if (o_vec[0] !== 3'd1) begin n_bad++; $display("FAIL err_setup_vector: got %0h expected 1", o_vec[0]); end
    ack = 1'b1; ret = 1'b1;
    cyc();
    ack = 1'b0; ret = 1'b0;
    n_cmp++; if (o_dep[0] !== 3'd0) begin n_bad++; $display("FAIL err_both_depth: got %0h expected 0", o_dep[0]); end
    n_cmp++; if (o_isv[0] !== 8'h00) begin n_bad++; $display("FAIL err_both_isv: got %0h expected 0", o_isv[0]); end
    n_cmp++; if (o_pend[0] !== 8'h02) begin n_bad++; $display("FAIL err_both_pending: got %0h expected 2", o_pend[0]); end
    n_cmp++; if (o_err[0] !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %0h expected 1", o_err[0]); end
  endtask

  task automatic test_level();
    do_reset();
    write_mask(8'h08);
    irq = 8'h08;
    cyc();
    n_cmp++; if (o_req[2] !== 1'b1) begin n_bad++; $display("FAIL level_req: got %0h expected 1", o_req[2]); end
    n_cmp++; if (o_vec[2] !== 3'd3) begin n_bad++; $display("FAIL level_vector: got %0h expected 3", o_vec[2]); end
    do_ack();
    n_cmp++; if (o_req[2] !== 1'b0) begin n_bad++; $display("FAIL level_busy_req: got %0h expected 0", o_req[2]); end
    n_cmp++; if (o_pend[2] !== 8'h08) begin n_bad++; $display("FAIL level_pending: got %0h expected 8", o_pend[2]); end
    n_cmp++; if (o_isv[2] !== 8'h08) begin n_bad++; $display("FAIL level_isv: got %0h expected 8", o_isv[2]); end
    do_ret();
    n_cmp++; if (o_req[2] !== 1'b1) begin n_bad++; $display("FAIL level_ret_req: got %0h expected 1", o_req[2]); end
    n_cmp++; if (o_vec[2] !== 3'd3) begin n_bad++; $display("FAIL level_ret_vector: got %0h expected 3", o_vec[2]); end
    irq = '0;
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    write_mask(8'hFF);
    pulse(8'h40); do_ack();
    pulse(8'h10); do_ack();
    pulse(8'h04); do_ack();
    pulse(8'h80);
    n_cmp++; if (o_dep[0] !== 3'd3) begin n_bad++; $display("FAIL arst_pre_depth: got %0h expected 3", o_dep[0]); end
    n_cmp++; if (o_pend[0] !== 8'h80) begin n_bad++; $display("FAIL arst_pre_pending: got %0h expected 80", o_pend[0]); end
    #2 reset = 1'b0;
    m_reset();
    #1;
    n_cmp++; if (o_req[0] !== 1'b0) begin n_bad++; $display("FAIL arst_req: got %0h expected 0", o_req[0]); end
    n_cmp++; if (o_vec[0] !== 3'd0) begin n_bad++; $display("FAIL arst_vector: got %0h expected 0", o_vec[0]); end
    n_cmp++; if (o_pend[0] !== 8'h00) begin n_bad++; $display("FAIL arst_pending: got %0h expected 0", o_pend[0]); end
    n_cmp++; if (o_isv[0] !== 8'h00) begin n_bad++; $display("FAIL arst_isv: got %0h expected 0", o_isv[0]); end
    n_cmp++; if (o_dep[0] !== 3'd0) begin n_bad++; $display("FAIL arst_depth: got %0h expected 0", o_dep[0]); end
    irq = 8'h02;
    @(negedge clk);
    cyc();
    reset = 1'b1;
    cyc(); cyc();
    write_mask(8'hFF);
    n_cmp++; if (o_pend[0] !== 8'h00) begin n_bad++; $display("FAIL arst_held_pending: got %0h expected 0", o_pend[0]); end
    n_cmp++; if (o_req[0] !== 1'b0) begin n_bad++; $display("FAIL arst_held_req: got %0h expected 0", o_req[0]); end
    irq = '0;
  endtask

  task automatic test_random();
    bit r;
    int v;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      irq     = 8'($urandom & $urandom & $urandom);
      mask_we = ($urandom_range(0, 7) == 0);
      mask_in = 8'($urandom);
      ack     = ($urandom_range(0, 2) == 0);
      ret     = ($urandom_range(0, 4) == 0);
      cyc();
      for (int k = 0; k < 3; k++) begin
        m_present(k, r, v);
        n_cmp++; if (o_req[k] !== r) begin n_bad++; $display("FAIL rand_req[%0d] cyc %0d: got %0h expected %0h", k, n, o_req[k], r); end
        n_cmp++; if (o_vec[k] !== 3'(v)) begin n_bad++; $display("FAIL rand_vector[%0d] cyc %0d: got %0h expected %0h", k, n, o_vec[k], v); end
        n_cmp++; if (o_pend[k] !== m_pend[k]) begin n_bad++; $display("FAIL rand_pending[%0d] cyc %0d: got %0h expected %0h", k, n, o_pend[k], m_pend[k]); end
        n_cmp++; if (o_isv[k] !== m_isv(k)) begin n_bad++; $display("FAIL rand_isv[%0d] cyc %0d: got %0h expected %0h", k, n, o_isv[k], m_isv(k)); end
        n_cmp++; if (o_dep[k] !== 3'(m_dep[k])) begin n_bad++; $display("FAIL rand_depth[%0d] cyc %0d: got %0h expected %0h", k, n, o_dep[k], m_dep[k]); end
        n_cmp++; if (o_err[k] !== m_err[k]) begin n_bad++; $display("FAIL rand_err[%0d] cyc %0d: got %0h expected %0h", k, n, o_err[k], m_err[k]); end
      end
    end
    irq = '0; ack = 1'b0; ret = 1'b0; mask_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq = '0; mask_we = 1'b0; mask_in = '0; ack = 1'b0; ret = 1'b0;
    m_reset();
    test_reset();
    test_basic();
    test_nesting();
    test_depth_limit();
    test_errors();
    test_level();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intr_controller.md
INTR_CONTROLLER -- requirements
Module: intr_controller

Interface
REQ-001 Parameter N_IRQ, default 8: number of interrupt channels, 2..32.
REQ-002 Parameter NEST_DEPTH, default 4: maximum nested in-service levels, 1..8.
REQ-003 Parameter EDGE_MODE, default 1: 1 = rising-edge-triggered channels, 0 = level-triggered channels.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 irq  in  N_IRQ  raw interrupt request lines, synchronous to clk.
REQ-007 mask_we  in  1  write strobe for the enable mask.
REQ-008 mask_in  in  N_IRQ  new enable mask; bit=1 enables channel.
REQ-009 ack  in  1  control unit accepts the presented interrupt (call).
REQ-010 ret  in  1  control unit returns from the current interrupt.
REQ-011 req  out  1  an eligible interrupt is being presented.
REQ-012 vector  out  clog2(N_IRQ)  index of the presented channel.
REQ-013 pending  out  N_IRQ  pending register.
REQ-014 in_service  out  N_IRQ  in-service bits.
REQ-015 depth  out  clog2(NEST_DEPTH+1)  current nesting level.
REQ-016 err  out  1  sticky protocol-error flag.

Function
REQ-017 Priority shall be fixed: lower channel index = higher priority; channel 0 is highest.
REQ-018 EDGE_MODE=1: a registered copy irq_q shall be kept; pending[i] shall be set at an edge where irq[i]=1 and irq_q[i]=0.
REQ-019 EDGE_MODE=0: pending shall load irq every clock; ack shall not clear it.
REQ-020 Pending shall latch regardless of mask; the mask gates eligibility only.
REQ-021 mask_we=1 shall load mask_in into the mask at the clock edge; the new mask takes effect in the following cycle.
REQ-022 A channel shall be eligible when pending=1, mask=1, in_service=0, its index is strictly lower than the stack top (any index if depth=0), and depth<NEST_DEPTH.
REQ-023 req shall be combinational from registered state: 1 iff any channel is eligible; vector = lowest eligible index, 0 when req=0.
REQ-024 Latency: an irq rising edge sampled at edge n shall produce req=1 in the cycle after edge n (one clock).
REQ-025 ack with req=1 shall, at one edge: push vector onto the nest stack, set in_service[vector], increment depth, and (EDGE_MODE=1) clear pending[vector].
REQ-026 If a new rising edge on the acked channel coincides with its ack, set shall win; pending stays 1.
REQ-027 ret with depth>0 shall pop the stack, clear in_service of the popped index, and decrement depth.
REQ-028 ack with req=0, or ret with depth=0, shall be ignored with no state change except err<=1.
REQ-029 ack and ret in the same cycle: ret shall be performed, ack ignored, err<=1.
REQ-030 depth=NEST_DEPTH shall force req=0; pending requests are held until a ret.
REQ-031 err shall stay 1 until reset.

Reset
REQ-032 On reset=0, asynchronously: pending, irq_q, mask, in_service, stack = 0; depth=0; err=0; hence req=0, vector=0.
REQ-033 Reset asserted mid-nesting shall discard all nesting and pending state; no request survives reset.
REQ-034 After reset release, the first clock edge shall sample irq_q from irq, so a line already high at release shall not register as an edge (EDGE_MODE=1).

Verification
REQ-035 Defaults, mask=0xFF, pulse irq[5] one cycle -> req=1, vector=5 one clock later; ack -> in_service=0x20, depth=1, pending[5]=0, req=0.
REQ-036 In service ch5, raise irq[2] and irq[6] -> req=1, vector=2; ack -> depth=2; ch6 held pending with req=0 until two rets, then vector=6.
REQ-037 NEST_DEPTH=2, fill two levels, then raise irq[0] -> req=0 until ret, then req=1, vector=0.
REQ-038 ret at depth=0, then ack with req=0, then ack+ret together at depth=1 -> err=1 after first; depth ends 0; no in_service bit set by the ignored acks.
REQ-039 EDGE_MODE=0, mask=0x08, hold irq[3]=1 -> req=1, vector=3; ack -> req=0 while in service; ret with irq[3] still high -> req=1 next cycle.
REQ-040 Depth=3 with pendings, assert reset asynchronously between edges -> all outputs 0 immediately; after release with irq[1] held high, req stays 0.
